// File: rtl/encoder_axil_responder_if.sv
// AXI4-Lite bus bundle for the encoder responder: one signal per AXI channel wire,
// with master/slave views.
interface encoder_axil_responder_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/encoder_axil_responder.sv
// AXI4-Lite register bank (CTRL, 3x SCRATCH, COUNT, STATUS) wrapped around a
// 4x quadrature decoder fed by synchronised encoder pins.
module encoder_axil_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    encoder_axil_responder_if.slave s_axi,
    input  logic                    enc_a,
    input  logic                    enc_b
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    logic                 live;
    logic                 aw_held, w_held, bvalid, rvalid;
    logic [IW-1:0]        aw_idx, ar_idx;
    logic [DW-1:0]        w_data, rdata, rd_mux, cnt_ext;
    logic [DW/8-1:0]      w_strb;
    logic [3:0][DW-1:0]   regs;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 dir, err;
    logic                 aw_hs, w_hs, ar_hs, wr_go;
    logic [1:0]           a_sync, b_sync;
    logic                 a_dly, b_dly;
    logic [1:0]           prev, cur;
    logic                 fwd, rev, bad, up;

    // live keeps every READY low while reset is asserted and for the first edge after
    assign s_axi.S_AXI_AWREADY = live && !aw_held && !bvalid;
    assign s_axi.S_AXI_WREADY  = live && !w_held && !bvalid;
    assign s_axi.S_AXI_ARREADY = live && !rvalid;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign wr_go  = aw_held && w_held;
    assign ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live    <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            live <= 1'b1;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi.S_AXI_WDATA;
                w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (wr_go) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
            end else if (bvalid && s_axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Only the four rw words are stored; RO/unmapped writes still get a response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs <= '0;
        end else if (wr_go && int'(aw_idx) < 4) begin
            for (int b = 0; b < DW/8; b++)
                if (w_strb[b]) regs[aw_idx[1:0]][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_WIDTH-1:0] = cnt;
        rd_mux = '0;
        case (int'(ar_idx))
            0, 1, 2, 3: rd_mux = regs[ar_idx[1:0]];
            4:          rd_mux = cnt_ext;
            5:          rd_mux = {{(DW-2){1'b0}}, err, dir};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
        end else if (rvalid && s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    // Gray decode: previous sample in the delay flops, current at the synchroniser output
    assign prev = {a_dly, b_dly};
    assign cur  = {a_sync[1], b_sync[1]};
    assign fwd  = (prev == 2'b00 && cur == 2'b01) || (prev == 2'b01 && cur == 2'b11) ||
                  (prev == 2'b11 && cur == 2'b10) || (prev == 2'b10 && cur == 2'b00);
    assign rev  = (prev == 2'b01 && cur == 2'b00) || (prev == 2'b11 && cur == 2'b01) ||
                  (prev == 2'b10 && cur == 2'b11) || (prev == 2'b00 && cur == 2'b10);
    assign bad  = (prev ^ cur) == 2'b11;
    assign up   = fwd ^ regs[0][2];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            a_sync <= '0;
            b_sync <= '0;
            a_dly  <= 1'b0;
            b_dly  <= 1'b0;
            cnt    <= '0;
            dir    <= 1'b0;
            err    <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], enc_a};
            b_sync <= {b_sync[0], enc_b};
            a_dly  <= a_sync[1];
            b_dly  <= b_sync[1];
            if (regs[0][1]) begin
                cnt <= '0;
                err <= 1'b0;
            end else begin
                if (bad) err <= 1'b1;
                if (regs[0][0] && (fwd || rev)) begin
                    dir <= up;
                    cnt <= up ? cnt + CNT_WIDTH'(1) : cnt - CNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_encoder_axil_responder.sv
// Self-checking bench: directed bus/encoder scenarios plus a randomized mix checked
// against a register/position model of the responder.
module tb_encoder_axil_responder;
    logic tb_ACLK;
    logic tb_ARESETN;
    logic enc_a, enc_b;
    int   n_chk, n_err;

    encoder_axil_responder_if bus ();

    encoder_axil_responder dut (
        .ACLK    (tb_ACLK),
        .ARESETN (tb_ARESETN),
        .s_axi   (bus),
        .enc_a   (enc_a),
        .enc_b   (enc_b)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference model: register words, encoder position and status
    logic [31:0] m_regs [4];
    logic [31:0] m_cnt;
    logic        m_err, m_dir;
    int          m_ph;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0: gray = 2'b00;
            1: gray = 2'b01;
            2: gray = 2'b11;
            default: gray = 2'b10;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int idx = int'(a[4:2]);
        if (idx < 4) return m_regs[idx];
        if (idx == 4) return m_cnt;
        if (idx == 5) return {30'd0, m_err, m_dir};
        return 32'd0;
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a[4:2]);
        if (idx < 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
        end
        if (m_regs[0][1]) begin
            m_cnt = 0;
            m_err = 1'b0;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_cnt = 0;
        m_err = 1'b0;
        m_dir = 1'b0;
    endtask

    // W is presented w_lead cycles ahead of AW; BREADY held low b_hold cycles
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input int b_hold);
        int   n;
        logic aw_done, w_done, aw_go, w_go, early;
        @(negedge tb_ACLK);
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = (w_lead == 0);
        aw_done = 1'b0; w_done = 1'b0; early = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 100) begin
            aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge tb_ACLK);
            n++;
            if (aw_go) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_go)  begin bus.S_AXI_WVALID = 1'b0;  w_done = 1'b1;  end
            if (!aw_done && bus.S_AXI_BVALID) early = 1'b1;
            if (!aw_done && !bus.S_AXI_AWVALID && n >= w_lead) bus.S_AXI_AWVALID = 1'b1;
        end
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        chk("b_before_aw", early, 1'b0);
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge tb_ACLK); n++; end
        chk("bvalid", bus.S_AXI_BVALID, 1'b1);
        repeat (b_hold) begin
            @(negedge tb_ACLK);
            chk("b_hold", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b100);
        end
        chk("bresp", bus.S_AXI_BRESP, 2'b00);
        bus.S_AXI_BREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_BREADY = 1'b0;
        chk("b_drop", bus.S_AXI_BVALID, 1'b0);
        m_write(a, d, s);
    endtask

    task automatic axi_read(input logic [4:0] a, input int r_hold, output logic [31:0] d);
        int n = 0;
        @(negedge tb_ACLK);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge tb_ACLK); n++; end
        chk("arready", bus.S_AXI_ARREADY, 1'b1);
        @(negedge tb_ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        chk("rvalid", bus.S_AXI_RVALID, 1'b1);
        d = bus.S_AXI_RDATA;
        repeat (r_hold) begin
            @(negedge tb_ACLK);
            chk("r_hold", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA}, {2'b10, d});
        end
        chk("rresp", bus.S_AXI_RRESP, 2'b00);
        bus.S_AXI_RREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_RREADY = 1'b0;
        chk("r_drop", bus.S_AXI_RVALID, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, 0, d);
        chk(tag, d, exp);
    endtask

    // kind: 0 forward step, 1 reverse step, 2 both pins toggle
    task automatic enc_move(input int kind);
        logic up;
        m_ph = (kind == 0) ? (m_ph + 1) % 4 : (kind == 1) ? (m_ph + 3) % 4 : (m_ph + 2) % 4;
        @(negedge tb_ACLK);
        {enc_a, enc_b} = gray(m_ph);
        if (!m_regs[0][1]) begin
            if (kind == 2) m_err = 1'b1;
            else if (m_regs[0][0]) begin
                up    = (kind == 0) ^ m_regs[0][2];
                m_cnt = up ? m_cnt + 1 : m_cnt - 1;
                m_dir = up;
            end
        end
        repeat (10) @(negedge tb_ACLK);
    endtask

    logic [31:0] vals [4];
    logic [31:0] rd;
    logic [4:0]  ra;
    int          op, n;

    initial begin
        n_chk = 0; n_err = 0; m_ph = 0;
        m_reset();
        vals = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        tb_ARESETN = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        chk("rst_hs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                       bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 5'b0);
        chk("rst_rdata", bus.S_AXI_RDATA, 32'h0);
        tb_ARESETN = 1'b1;
        @(negedge tb_ACLK);
        chk("post_rst_rdy", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

        // rw registers round-trip
        for (int a = 0; a < 4; a++)
            for (int v = 0; v < 4; v++) begin
                axi_write(5'(a * 4), vals[v], 4'hF, 0, 0);
                rd_chk("rw_readback", 5'(a * 4), vals[v]);
            end

        // W leads AW by two cycles, partial strobe
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_write(5'h04, 32'h12345678, 4'b0011, 2, 0);
        rd_chk("wstrb_merge", 5'h04, 32'hFFFF5678);

        // counting up, then through zero downwards
        axi_write(5'h00, 32'h1, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) enc_move(0);
        rd_chk("count_fwd", 5'h10, 32'd5);
        for (int i = 0; i < 7; i++) enc_move(1);
        rd_chk("count_wrap", 5'h10, 32'hFFFFFFFE);
        rd_chk("status_down", 5'h14, 32'h0);

        // illegal double transition and clear
        enc_move(2);
        rd_chk("count_illegal", 5'h10, 32'hFFFFFFFE);
        rd_chk("status_err", 5'h14, 32'h2);
        axi_write(5'h00, 32'h3, 4'hF, 0, 0);
        axi_write(5'h00, 32'h1, 4'hF, 0, 0);
        rd_chk("status_clr", 5'h14, 32'h0);
        rd_chk("count_clr", 5'h10, 32'h0);

        // backpressure on B and R, write to read-only COUNT
        axi_write(5'h10, 32'hCAFEF00D, 4'hF, 0, 5);
        axi_read(5'h10, 5, rd);
        chk("count_ro", rd, 32'h0);

        // randomized mix against the model
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            ra = {3'($urandom_range(0, 7)), 2'b00};
            if (op < 3)
                axi_write(ra, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            else if (op < 6)
                rd_chk("rnd_read", ra, m_read(ra));
            else if (op < 9)
                enc_move(op - 6);
            else
                axi_write(5'h00, $urandom & 32'hFFFFFFFD, 4'hF, 0, 0);
        end
        for (int a = 0; a < 8; a++) rd_chk("rnd_final", 5'(a * 4), m_read(5'(a * 4)));

        // reset while a write response is pending
        @(negedge tb_ACLK);
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h55AA55AA; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge tb_ACLK); n++; end
        chk("pre_rst_bvalid", bus.S_AXI_BVALID, 1'b1);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        tb_ARESETN = 1'b0;
        #1;
        chk("rst_bvalid", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                           bus.S_AXI_ARREADY}, 4'b0);
        enc_a = 1'b0; enc_b = 1'b0; m_ph = 0;
        m_reset();
        repeat (2) @(negedge tb_ACLK);
        tb_ARESETN = 1'b1;
        repeat (2) @(negedge tb_ACLK);
        for (int a = 0; a < 8; a++) rd_chk("after_rst", 5'(a * 4), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
